// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: two requesters share one sequential radix-2 Booth
// multiplier. The arbiter is round-robin. Each operation takes WIDTH Booth
// steps, and result holds the most recent signed product.
module booth_mult_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 owner
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               last_r;
  logic [2*WIDTH:0]   acc_r;
  logic [2*WIDTH:0]   acc_s;
  logic               qm1_r;
  logic [WIDTH:0]     mcand_r;
  logic [CW-1:0]      cnt_r;
  logic               grant_s;
  logic               gnt_id_s;
  logic [WIDTH-1:0]   a_sel_s;
  logic [WIDTH-1:0]   b_sel_s;
  logic [WIDTH:0]     hi_s;
  logic [WIDTH:0]     sum_s;

  // Round-robin arbitration: a lone requester wins; a tie goes to the one not served last
  always_comb begin
    grant_s = req0 | req1;
    if (req0 && req1) begin
      gnt_id_s = ~last_r;
    end else if (req1) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
    if (gnt_id_s) begin
      a_sel_s = a1;
      b_sel_s = b1;
    end else begin
      a_sel_s = a0;
      b_sel_s = b0;
    end
  end

  // One Booth step: add or subtract the multiplicand on bit pair {q0,q-1}, then arithmetic shift right
  always_comb begin
    hi_s = acc_r[2*WIDTH:WIDTH];
    case ({acc_r[0], qm1_r})
      2'b01:   sum_s = hi_s + mcand_r;
      2'b10:   sum_s = hi_s - mcand_r;
      default: sum_s = hi_s;
    endcase
    acc_s = {sum_s[WIDTH], sum_s, acc_r[WIDTH-1:1]};
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_STEP) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered handshake outputs; the operands are latched at grant so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
      owner   <= 1'b0;
      last_r  <= 1'b1;
      acc_r   <= '0;
      qm1_r   <= 1'b0;
      mcand_r <= '0;
      cnt_r   <= '0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            owner   <= gnt_id_s;
            last_r  <= gnt_id_s;
            ack0    <= ~gnt_id_s;
            ack1    <= gnt_id_s;
            mcand_r <= {a_sel_s[WIDTH-1], a_sel_s};
            acc_r   <= {{(WIDTH+1){1'b0}}, b_sel_s};
            qm1_r   <= 1'b0;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          acc_r <= acc_s;
          qm1_r <= acc_r[0];
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_STEP) begin
            result <= acc_s[2*WIDTH-1:0];
            done0  <= ~owner;
            done1  <= owner;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Testbench for booth_mult_arbiter. A table of operand/product vectors
// drives single operations. Hand-written sequences cover the tie, reset
// abort and fairness cases. A scoreboard queue holds the expected
// {requester, product} of each operation and is checked on every done pulse.
module tb_booth_mult_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic               req0, req1;
  logic [WIDTH-1:0]   a0, b0, a1, b1;
  logic               ack0, ack1, done0, done1;
  logic [2*WIDTH-1:0] result;
  logic               busy, owner;

  typedef struct {
    bit id;
    int prod;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int prod;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  booth_mult_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected operation
  always @(negedge clk) begin
    if (rst_n && (done0 || done1)) begin
      exp_t e;
      done_cnt++;
      chk("done_exclusive", int'(done0 & done1), 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_id", int'(done1), int'(e.id));
        chk("done_owner", int'(owner), int'(e.id));
        chk("done_result", int'($signed(result)), e.prod);
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_ack"}, int'({ack1, ack0}), 0);
    chk({name, "_done"}, int'({done1, done0}), 0);
    chk({name, "_result"}, int'(result), 0);
    chk({name, "_owner"}, int'(owner), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single operation from one requester with latency and hold checks
  task automatic run_op(input bit id, input int a, input int b, input int prod);
    int n;
    @(negedge clk);
    if (id) begin
      req1 = 1'b1; a1 = a[WIDTH-1:0]; b1 = b[WIDTH-1:0];
    end else begin
      req0 = 1'b1; a0 = a[WIDTH-1:0]; b0 = b[WIDTH-1:0];
    end
    sb.push_back('{id, prod});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? ack1 : ack0) && n < 20);
    chk("ack_latency", n, 1);
    chk("ack_other", int'(id ? ack0 : ack1), 0);
    req0 = 1'b0;
    req1 = 1'b0;
    // scramble operands: the operation in progress must ignore them
    a0 = 8'h5a; b0 = 8'ha5; a1 = 8'h33; b1 = 8'hcc;
    n = 0;
    while (!(id ? done1 : done0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, WIDTH);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("result_hold", int'($signed(result)), prod);
  endtask

  initial begin
    vec_t vecs[8];
    int c0, c1, j, start;

    vecs[0] = '{124, 73, 9052};
    vecs[1] = '{-128, -128, 16384};
    vecs[2] = '{-128, 127, -16256};
    vecs[3] = '{0, -5, 0};
    vecs[4] = '{-1, -1, 1};
    vecs[5] = '{127, 127, 16129};
    vecs[6] = '{127, -128, -16256};
    vecs[7] = '{-7, 6, -42};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table-driven single operations, alternating requesters
    for (int i = 0; i < 8; i++) begin
      run_op(i[0], vecs[i].a, vecs[i].b, vecs[i].prod);
    end

    // Tie right after reset: requester 0 first, second capture 10 cycles later
    do_reset();
    @(negedge clk);
    req0 = 1'b1; a0 = 8'd49; b0 = 8'd49;
    req1 = 1'b1; a1 = 8'd52; b1 = 8'd63;
    sb.push_back('{1'b0, 2401});
    sb.push_back('{1'b1, 3276});
    c0 = -1;
    c1 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack0) begin c0 = k; req0 = 1'b0; end
      if (ack1) begin c1 = k; req1 = 1'b0; end
      if (c1 >= 0 && !busy) break;
    end
    chk("tie_first_ack", c0, 1);
    chk("tie_gap", c1 - c0, WIDTH + 2);
    chk("tie_sb_empty", sb.size(), 0);

    // Reset three cycles into RUN aborts the operation immediately
    @(negedge clk);
    req0 = 1'b1; a0 = 8'd7; b0 = 8'd7;
    sb.push_back('{1'b0, 49});
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!ack0 && j < 20);
    chk("abort_ack", j, 1);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    run_op(1'b1, 5, 9, 45);

    // Fairness: both held continuously for six operations
    do_reset();
    start = done_cnt;
    @(negedge clk);
    req0 = 1'b1; a0 = 8'd3;   b0 = 8'hf9;
    req1 = 1'b1; a1 = 8'hf5;  b1 = 8'd13;
    for (int k = 0; k < 6; k++) begin
      if (k[0]) sb.push_back('{1'b1, -143});
      else      sb.push_back('{1'b0, -21});
    end
    j = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        chk("fair_owner", int'(owner), j % 2);
        j++;
      end
      if (done_cnt == start + 6) begin
        req0 = 1'b0;
        req1 = 1'b0;
        break;
      end
    end
    repeat (4) @(negedge clk);
    chk("fair_grants", j, 6);
    chk("fair_dones", done_cnt - start, 6);
    chk("fair_sb_empty", sb.size(), 0);
    chk("fair_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mult_arbiter.md
BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; the product is 2*WIDTH bits.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0  input  1  requester 0 asks for a multiply; held high until ack0.
REQ-005 a0, b0  input  WIDTH each  requester 0 signed operands; stable while req0 is high.
REQ-006 req1  input  1  requester 1 asks for a multiply; held high until ack1.
REQ-007 a1, b1  input  WIDTH each  requester 1 signed operands; stable while req1 is high.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: operands of that requester have been captured.
REQ-009 done0, done1  output  1 each  one-cycle pulse: result is valid for that requester.
REQ-010 result  output  2*WIDTH  signed product of the most recently completed operation.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 owner  output  1  index of the requester currently being served, or last served.

Function
REQ-013 The block SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE, with state registered on clk.
REQ-014 In IDLE, if any req is high at a rising edge, the block SHALL grant it, capture its operands, set owner, clear the step counter and enter RUN.
REQ-015 Arbitration SHALL be round-robin: a lone requester wins; on simultaneous requests, the requester not equal to last_served wins.
REQ-016 last_served SHALL update at each grant.
REQ-017 ack of the granted requester SHALL be high for exactly the first RUN cycle; the other ack SHALL stay low.
REQ-018 RUN SHALL perform one exact radix-2 Booth step per edge (add/subtract multiplicand per bit pair {q0,q-1}, arithmetic shift right).
REQ-019 The accumulator SHALL be 2*WIDTH+1 bits wide, so the most negative operand (-2^(WIDTH-1)) multiplies correctly.
REQ-020 After WIDTH steps (the WIDTH-th edge after capture) the block SHALL load result, enter DONE and assert the owner's done for that one cycle.
REQ-021 DONE SHALL return to IDLE on the next edge, so the capture-to-capture period is WIDTH+2 cycles.
REQ-022 result SHALL equal the exact two's-complement product a*b and SHALL hold its value until the next DONE.
REQ-023 Requests SHALL be ignored in RUN and DONE; a request held through an operation is considered at the next IDLE edge.
REQ-024 Operand changes after capture SHALL NOT affect the operation in progress.
REQ-025 A req that drops before ack SHALL simply not be granted; no error state.

Reset
REQ-026 On rst_n low the block SHALL asynchronously force:
- state = IDLE
- ack0/ack1/done0/done1 = 0
- busy = 0
- result = 0
- owner = 0
- last_served = 1, so requester 0 wins the first tie
- accumulator and counter = 0
REQ-027 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first request after rst_n rises SHALL be served normally.

Verification
REQ-028 Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
REQ-029 Single operation: req0 with a0=124, b0=73 ->
- ack0 high in cycle 1 after the capture edge
- done0 high 8 edges after capture
- result = 9052; done1 never asserted
REQ-030 Tie after reset: req0 (49*49) and req1 (52*63) both held ->
- served in order 0 then 1
- result 2401 with done0, then 3276 with done1
- second capture 10 cycles after the first
REQ-031 Corner operands:
- -128*-128 -> 16384
- -128*127 -> -16256
- 0*-5 -> 0
- -1*-1 -> 1
REQ-032 Reset mid-operation: drop rst_n 3 cycles into RUN -> no done, busy = 0; a subsequent req1 with 5*9 -> result 45 with done1.
REQ-033 Fairness: req0 and req1 held continuously for 6 operations -> owner alternates 0,1,0,1,0,1 and each done matches owner.
